// File: rtl/wavegen_dds_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wavegen_dds_core_pkg
// Description : Shared types, default widths and arithmetic helpers for the
//               wavegen DDS core (waveform enum, mode decode, saturation).
// Ports       : none (package)
// Revision    : 1.0 - initial N-channel release
// ============================================================================
package wavegen_dds_core_pkg;

    typedef enum logic [2:0] {
        WAVE_DC   = 3'd0,
        WAVE_SINE = 3'd1,
        WAVE_SAW  = 3'd2,
        WAVE_TRI  = 3'd3,
        WAVE_SQR  = 3'd4
    } wave_mode_t;

    localparam int unsigned c_n_ch      = 2;
    localparam int unsigned c_acc_w     = 32;
    localparam int unsigned c_addr_w    = 12;
    localparam int unsigned c_samp_w    = 16;
    // Gain is Q1.15, so the product is renormalised by 15 fractional bits.
    localparam int unsigned c_gain_frac = 15;

    // Unused encodings 5..7 collapse to DC so the output stays well defined.
    function automatic wave_mode_t to_wave_mode(input logic [2:0] m);
        case (m)
            3'd1:    return WAVE_SINE;
            3'd2:    return WAVE_SAW;
            3'd3:    return WAVE_TRI;
            3'd4:    return WAVE_SQR;
            default: return WAVE_DC;
        endcase
    endfunction

    // Add two wide signed values and clamp the result to a w-bit signed range.
    // Operands are far narrower than 64 bits, so the sum itself cannot wrap.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wavegen_dds_core_if.sv
`default_nettype none
// ============================================================================
// Module      : wavegen_dds_core_if
// Description : Control, configuration, LUT and sample bundle of the DDS core.
//               master : register bank / LUT / DAC side
//               slave  : DDS core
// Signals     : en, tick, phase_sync       run control strobes
//               mode, freq, phase_ofs,     per-channel configuration arrays
//               amp, offset
//               lut_addr / lut_data        external sine LUT (1-clk read)
//               sample, sample_valid       signed output samples
// Revision    : 1.0 - initial N-channel release
// ============================================================================
interface wavegen_dds_core_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned SAMP_W = 16
);
    logic                             en;
    logic                             tick;
    logic                             phase_sync;
    logic [N_CH-1:0][2:0]             mode;
    logic [N_CH-1:0][ACC_W-1:0]       freq;
    logic [N_CH-1:0][ADDR_W-1:0]      phase_ofs;
    logic [N_CH-1:0][SAMP_W-1:0]      amp;
    logic [N_CH-1:0][SAMP_W-1:0]      offset;
    logic [N_CH-1:0][ADDR_W-1:0]      lut_addr;
    logic [N_CH-1:0][SAMP_W-1:0]      lut_data;
    logic [N_CH-1:0][SAMP_W-1:0]      sample;
    logic                             sample_valid;

    modport master (
        output en, tick, phase_sync, mode, freq, phase_ofs, amp, offset, lut_data,
        input  lut_addr, sample, sample_valid
    );

    modport slave (
        input  en, tick, phase_sync, mode, freq, phase_ofs, amp, offset, lut_data,
        output lut_addr, sample, sample_valid
    );
endinterface
`default_nettype wire

// File: rtl/wavegen_dds_core_channel.sv
`default_nettype none
// ============================================================================
// Module      : wavegen_dds_core_channel
// Description : One DDS channel: phase accumulator, LUT address, waveform
//               synthesis, Q1.15 gain, DC offset and saturation.
//               Stage strobes come from the shared valid pipeline in the top.
// Ports       : clk, reset            clock, synchronous active-high reset
//               i_s0_fire..i_s3_fire  stage advance strobes (S0 = tick & en)
//               i_phase_sync          zero the accumulator
//               i_mode, i_freq, i_phase_ofs, i_amp, i_offset   configuration
//               i_lut_data            LUT sample for o_lut_addr, 1 clk later
//               o_lut_addr            LUT address
//               o_sample              signed output sample
// Revision    : 1.0 - initial N-channel release
// ============================================================================
module wavegen_dds_core_channel
    import wavegen_dds_core_pkg::*;
#(
    parameter int unsigned ACC_W  = c_acc_w,
    parameter int unsigned ADDR_W = c_addr_w,
    parameter int unsigned SAMP_W = c_samp_w
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_s0_fire,
    input  wire logic                     i_s1_fire,
    input  wire logic                     i_s2_fire,
    input  wire logic                     i_s3_fire,
    input  wire logic                     i_phase_sync,
    input  wire logic [2:0]               i_mode,
    input  wire logic [ACC_W-1:0]         i_freq,
    input  wire logic [ADDR_W-1:0]        i_phase_ofs,
    input  wire logic [SAMP_W-1:0]        i_amp,
    input  wire logic signed [SAMP_W-1:0] i_offset,
    input  wire logic signed [SAMP_W-1:0] i_lut_data,
    output logic [ADDR_W-1:0]             o_lut_addr,
    output logic signed [SAMP_W-1:0]      o_sample
);

    localparam logic signed [SAMP_W-1:0] c_sqr_pos = {1'b0, {(SAMP_W-1){1'b1}}};
    localparam logic signed [SAMP_W-1:0] c_sqr_neg = {1'b1, {(SAMP_W-2){1'b0}}, 1'b1};

    logic [ACC_W-1:0]         r_acc;
    logic [ACC_W-1:0]         w_acc_next;
    logic [ADDR_W-1:0]        r_lut_addr;
    logic [ADDR_W-1:0]        r_ph2;
    wave_mode_t               r_mode1;
    wave_mode_t               r_mode2;
    logic [SAMP_W-1:0]        r_amp1;
    logic [SAMP_W-1:0]        r_amp2;
    logic [SAMP_W-1:0]        r_amp3;
    logic signed [SAMP_W-1:0] r_ofs1;
    logic signed [SAMP_W-1:0] r_ofs2;
    logic signed [SAMP_W-1:0] r_ofs3;
    logic signed [SAMP_W-1:0] r_raw3;
    logic signed [SAMP_W-1:0] r_sample;

    logic [ADDR_W-1:0]        w_saw_ph;
    logic [ADDR_W-2:0]        w_tri_t;
    logic [SAMP_W-1:0]        w_tri_u;
    logic signed [SAMP_W-1:0] w_raw;
    logic signed [63:0]       w_prod;
    logic signed [63:0]       w_scaled;
    logic signed [SAMP_W-1:0] w_y;

    // Sync wins over a coincident tick, so that sample is taken at phase 0.
    assign w_acc_next = i_phase_sync ? '0 : r_acc + i_freq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_phase_sync || i_s0_fire) begin
            r_acc <= w_acc_next;
        end
    end

    // S0: the LUT address is built from the updated accumulator so that a
    // registered LUT returns data in time for S2. Per-sample configuration is
    // frozen here and travels with the sample, so a sample never mixes configs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lut_addr <= '0;
            r_mode1    <= WAVE_DC;
            r_amp1     <= '0;
            r_ofs1     <= '0;
        end else if (i_s0_fire) begin
            r_lut_addr <= w_acc_next[ACC_W-1 -: ADDR_W] + i_phase_ofs;
            r_mode1    <= to_wave_mode(i_mode);
            r_amp1     <= i_amp;
            r_ofs1     <= i_offset;
        end
    end

    // S1: LUT read in flight; keep the phase for the synthetic waveforms.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ph2   <= '0;
            r_mode2 <= WAVE_DC;
            r_amp2  <= '0;
            r_ofs2  <= '0;
        end else if (i_s1_fire) begin
            r_ph2   <= r_lut_addr;
            r_mode2 <= r_mode1;
            r_amp2  <= r_amp1;
            r_ofs2  <= r_ofs1;
        end
    end

    // S2 waveform generation. Phase-derived shapes are left-justified into
    // the sample width by placing them at the top of a wide vector.
    always_comb begin
        w_saw_ph = {~r_ph2[ADDR_W-1], r_ph2[ADDR_W-2:0]};
        w_tri_t  = r_ph2[ADDR_W-1] ? ~r_ph2[ADDR_W-2:0] : r_ph2[ADDR_W-2:0];
        w_tri_u  = SAMP_W'({w_tri_t, {SAMP_W{1'b0}}} >> (ADDR_W - 1));
        w_raw    = '0;
        case (r_mode2)
            WAVE_SINE: w_raw = i_lut_data;
            WAVE_SAW:  w_raw = SAMP_W'({w_saw_ph, {SAMP_W{1'b0}}} >> ADDR_W);
            // Unsigned 0..max folded ramp re-centred by flipping its MSB.
            WAVE_TRI:  w_raw = {~w_tri_u[SAMP_W-1], w_tri_u[SAMP_W-2:0]};
            WAVE_SQR:  w_raw = r_ph2[ADDR_W-1] ? c_sqr_neg : c_sqr_pos;
            default:   w_raw = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_raw3 <= '0;
            r_amp3 <= '0;
            r_ofs3 <= '0;
        end else if (i_s2_fire) begin
            r_raw3 <= w_raw;
            r_amp3 <= r_amp2;
            r_ofs3 <= r_ofs2;
        end
    end

    // S3: signed raw times unsigned gain, arithmetic shift, offset, clamp.
    always_comb begin
        w_prod   = $signed({{(64-SAMP_W){r_raw3[SAMP_W-1]}}, r_raw3})
                 * $signed({{(64-SAMP_W){1'b0}}, r_amp3});
        w_scaled = w_prod >>> c_gain_frac;
        w_y      = SAMP_W'(sat_add(w_scaled,
                                   $signed({{(64-SAMP_W){r_ofs3[SAMP_W-1]}}, r_ofs3}),
                                   SAMP_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= '0;
        end else if (i_s3_fire) begin
            r_sample <= w_y;
        end
    end

    assign o_lut_addr = r_lut_addr;
    assign o_sample   = r_sample;

endmodule
`default_nettype wire

// File: rtl/wavegen_dds_core.sv
`default_nettype none
// ============================================================================
// Module      : wavegen_dds_core
// Description : N-channel DDS engine. Shares one tick/valid pipeline across
//               all channels so every channel's sample updates together.
//               Tick accepted on edge T -> sample_valid high after edge T+3.
// Ports       : clk    system clock
//               reset  synchronous active-high reset (drops in-flight samples)
//               bus    wavegen_dds_core_if.slave: en, tick, phase_sync,
//                      mode/freq/phase_ofs/amp/offset, lut_addr/lut_data,
//                      sample/sample_valid
//               Parameters must match those of the connected interface.
// Revision    : 1.0 - initial N-channel release
// ============================================================================
module wavegen_dds_core
    import wavegen_dds_core_pkg::*;
#(
    parameter int unsigned N_CH   = c_n_ch,
    parameter int unsigned ACC_W  = c_acc_w,
    parameter int unsigned ADDR_W = c_addr_w,
    parameter int unsigned SAMP_W = c_samp_w
) (
    input  wire logic          clk,
    input  wire logic          reset,
    wavegen_dds_core_if.slave  bus
);

    logic w_s0_fire;
    logic r_v1;
    logic r_v2;
    logic r_v3;
    logic r_sample_valid;

    // Ticks are ignored while disabled; samples already in flight still drain.
    assign w_s0_fire = bus.tick & bus.en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1           <= 1'b0;
            r_v2           <= 1'b0;
            r_v3           <= 1'b0;
            r_sample_valid <= 1'b0;
        end else begin
            r_v1           <= w_s0_fire;
            r_v2           <= r_v1;
            r_v3           <= r_v2;
            r_sample_valid <= r_v3;
        end
    end

    assign bus.sample_valid = r_sample_valid;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        wavegen_dds_core_channel #(
            .ACC_W  (ACC_W),
            .ADDR_W (ADDR_W),
            .SAMP_W (SAMP_W)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .i_s0_fire    (w_s0_fire),
            .i_s1_fire    (r_v1),
            .i_s2_fire    (r_v2),
            .i_s3_fire    (r_v3),
            .i_phase_sync (bus.phase_sync),
            .i_mode       (bus.mode[g]),
            .i_freq       (bus.freq[g]),
            .i_phase_ofs  (bus.phase_ofs[g]),
            .i_amp        (bus.amp[g]),
            .i_offset     (bus.offset[g]),
            .i_lut_data   (bus.lut_data[g]),
            .o_lut_addr   (bus.lut_addr[g]),
            .o_sample     (bus.sample[g])
        );
    end

endmodule
`default_nettype wire
